// File: rtl/params_pkg.sv
// Shared widths, enums and defaults for the memory request path.
package params_pkg;

  localparam int PADDR_WIDTH      = 32;
  localparam int CACHE_LINE_BYTES = 4;
  localparam int ARB_TIMEOUT_DEF  = 1024;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD,
    SIZE_LINE
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D_RD,
    GRANT_D_WR
  } arb_state_t;

  typedef enum logic {
    CLIENT_I,
    CLIENT_D
  } arb_client_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating grant-cycle counter; raises a sticky flag once it reaches TIMEOUT_CYC.
// The flag is set on the same edge the counter reaches the limit and holds until reset.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int            CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_d == LIMIT) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter merging fetch and data requests onto one memory port,
// one transaction outstanding; responses are steered back to the owning client.
module mem_req_arbiter
  import params_pkg::*;
#(
  parameter int ADDR_W      = PADDR_WIDTH,
  parameter int LINE_W      = CACHE_LINE_BYTES * 8,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_data_valid_o,
  output logic [LINE_W-1:0] i_data_o,
  input  logic              d_rd_req_i,
  input  logic              d_wr_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wr_data_i,
  input  access_size_t      d_size_i,
  output logic              d_data_valid_o,
  output logic [LINE_W-1:0] d_data_o,
  output logic              d_write_done_o,
  output logic              mem_rd_req_valid_o,
  output logic              mem_wr_req_valid_o,
  output logic              mem_req_is_instr_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [LINE_W-1:0] mem_wr_data_o,
  output access_size_t      mem_access_size_o,
  input  logic              mem_data_valid_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_write_done_i,
  output logic              timeout_o
);

  arb_state_t        state_q;
  arb_client_t       last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  access_size_t      size_q;
  logic              is_instr_q;

  logic d_req, pick_i, grant, rd_resp, wr_resp;

  // Fetch wins when it is alone, or on a tie when data was served last.
  always_comb begin
    d_req   = d_rd_req_i | d_wr_req_i;
    pick_i  = i_rd_req_i & (~d_req | (last_grant_q == CLIENT_D));
    grant   = (state_q == IDLE) & (i_rd_req_i | d_req);
    rd_resp = mem_data_valid_i & ((state_q == GRANT_I) | (state_q == GRANT_D_RD));
    wr_resp = mem_write_done_i & (state_q == GRANT_D_WR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= CLIENT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= SIZE_BYTE;
      is_instr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant && pick_i) begin
            state_q      <= GRANT_I;
            last_grant_q <= CLIENT_I;
            addr_q       <= i_addr_i;
            size_q       <= SIZE_WORD;
            is_instr_q   <= 1'b1;
          end else if (grant) begin
            // A simultaneous read+write request is treated as a write.
            state_q      <= d_wr_req_i ? GRANT_D_WR : GRANT_D_RD;
            last_grant_q <= CLIENT_D;
            addr_q       <= d_addr_i;
            wdata_q      <= d_wr_data_i;
            size_q       <= d_size_i;
            is_instr_q   <= 1'b0;
          end
        end
        GRANT_I, GRANT_D_RD: if (rd_resp) state_q <= IDLE;
        GRANT_D_WR:          if (wr_resp) state_q <= IDLE;
        default:             state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_req_valid_o = (state_q == GRANT_I) | (state_q == GRANT_D_RD);
  assign mem_wr_req_valid_o = (state_q == GRANT_D_WR);
  assign mem_req_is_instr_o = is_instr_q;
  assign mem_address_o      = addr_q;
  assign mem_wr_data_o      = wdata_q;
  assign mem_access_size_o  = size_q;

  assign i_data_valid_o = mem_data_valid_i & (state_q == GRANT_I);
  assign d_data_valid_o = mem_data_valid_i & (state_q == GRANT_D_RD);
  assign d_write_done_o = wr_resp;
  assign i_data_o       = mem_data_i;
  assign d_data_o       = mem_data_i;

  mem_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (grant),
    .en_i     ((state_q != IDLE) & ~rd_resp & ~wr_resp),
    .timeout_o(timeout_o)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench: per-cycle vector table for control outputs, plus hand sequences for latching.
module tb_mem_req_arbiter;
  import params_pkg::*;

  localparam int AW = 32;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_rd_req, d_rd_req, d_wr_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wr_data, mem_data;
  access_size_t  d_size;
  logic          mem_dv, mem_wd;

  logic          i_dv, d_dv, d_wd, m_rdv, m_wrv, m_instr, to;
  logic [LW-1:0] i_data, d_data, m_wdata;
  logic [AW-1:0] m_addr;
  access_size_t  m_size;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_rd_req_i        (i_rd_req),
    .i_addr_i          (i_addr),
    .i_data_valid_o    (i_dv),
    .i_data_o          (i_data),
    .d_rd_req_i        (d_rd_req),
    .d_wr_req_i        (d_wr_req),
    .d_addr_i          (d_addr),
    .d_wr_data_i       (d_wr_data),
    .d_size_i          (d_size),
    .d_data_valid_o    (d_dv),
    .d_data_o          (d_data),
    .d_write_done_o    (d_wd),
    .mem_rd_req_valid_o(m_rdv),
    .mem_wr_req_valid_o(m_wrv),
    .mem_req_is_instr_o(m_instr),
    .mem_address_o     (m_addr),
    .mem_wr_data_o     (m_wdata),
    .mem_access_size_o (m_size),
    .mem_data_valid_i  (mem_dv),
    .mem_data_i        (mem_data),
    .mem_write_done_i  (mem_wd),
    .timeout_o         (to)
  );

  // in:  {rst, i_rd, d_rd, d_wr, mem_dv, mem_wd}
  // exp: {mem_rd_v, mem_wr_v, is_instr, i_dv, d_dv, d_wdone, timeout}
  typedef struct packed {
    logic [5:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [5:0] in, input logic [6:0] exp);
    vec_t r;
    r.in  = in;
    r.exp = exp;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] outs;

    rst = 1'b0; i_rd_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
    i_addr = 32'h1000; d_addr = 32'h2004; d_wr_data = 32'h1234_5678;
    d_size = SIZE_WORD; mem_data = 32'h0BAD_F00D; mem_dv = 1'b0; mem_wd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_addr",    64'(m_addr),  64'h0);
    check("reset_wdata",   64'(m_wdata), 64'h0);
    check("reset_timeout", 64'(to),      64'h0);

    // fetch alone, stray write_done ignored, response on 4th grant cycle
    tbl.push_back(v(6'b000000, 7'b0000000));
    tbl.push_back(v(6'b110000, 7'b0000000));
    tbl.push_back(v(6'b110000, 7'b1010000));
    tbl.push_back(v(6'b110001, 7'b1010000));
    tbl.push_back(v(6'b110000, 7'b1010000));
    tbl.push_back(v(6'b110010, 7'b1011000));
    tbl.push_back(v(6'b100000, 7'b0010000));
    // reset, then fetch+load tie alternating I,D,I,D
    tbl.push_back(v(6'b000000, 7'b0010000));
    tbl.push_back(v(6'b111000, 7'b0000000));
    tbl.push_back(v(6'b111000, 7'b1010000));
    tbl.push_back(v(6'b111010, 7'b1011000));
    tbl.push_back(v(6'b111000, 7'b0010000));
    tbl.push_back(v(6'b111010, 7'b1000100));
    tbl.push_back(v(6'b111000, 7'b0000000));
    tbl.push_back(v(6'b111010, 7'b1011000));
    tbl.push_back(v(6'b111000, 7'b0010000));
    tbl.push_back(v(6'b111010, 7'b1000100));
    tbl.push_back(v(6'b100000, 7'b0000000));
    // store with stray data_valid
    tbl.push_back(v(6'b100100, 7'b0000000));
    tbl.push_back(v(6'b100100, 7'b0100000));
    tbl.push_back(v(6'b100110, 7'b0100000));
    tbl.push_back(v(6'b100101, 7'b0100010));
    tbl.push_back(v(6'b100000, 7'b0000000));
    // rd+wr together -> write
    tbl.push_back(v(6'b101100, 7'b0000000));
    tbl.push_back(v(6'b101110, 7'b0100000));
    tbl.push_back(v(6'b101101, 7'b0100010));
    tbl.push_back(v(6'b100000, 7'b0000000));
    // silent memory: timeout after 8 grant cycles, sticky past response
    tbl.push_back(v(6'b110000, 7'b0000000));
    for (int k = 0; k < 8; k++) tbl.push_back(v(6'b110000, 7'b1010000));
    tbl.push_back(v(6'b110000, 7'b1010001));
    tbl.push_back(v(6'b110010, 7'b1011001));
    tbl.push_back(v(6'b100000, 7'b0010001));
    tbl.push_back(v(6'b000000, 7'b0010001));
    tbl.push_back(v(6'b100000, 7'b0000000));
    // reset mid-read, late responses ignored
    tbl.push_back(v(6'b101000, 7'b0000000));
    tbl.push_back(v(6'b101000, 7'b1000000));
    tbl.push_back(v(6'b001000, 7'b1000000));
    tbl.push_back(v(6'b100000, 7'b0000000));
    tbl.push_back(v(6'b100010, 7'b0000000));
    tbl.push_back(v(6'b100001, 7'b0000000));

    foreach (tbl[k]) begin
      {rst, i_rd_req, d_rd_req, d_wr_req, mem_dv, mem_wd} = tbl[k].in;
      @(negedge clk);
      outs = {m_rdv, m_wrv, m_instr, i_dv, d_dv, d_wd, to};
      n_vec++;
      if (outs !== tbl[k].exp) begin
        n_err++;
        $display("FAIL vec%0d: got %b expected %b", k, outs, tbl[k].exp);
      end
      next_cycle();
    end

    // fetch latches address and word size; address change mid-grant has no effect
    {rst, i_rd_req, d_rd_req, d_wr_req, mem_dv, mem_wd} = 6'b110000;
    i_addr = 32'h1000;
    next_cycle();
    i_addr = 32'h5555;
    #2;
    check("f_addr",  64'(m_addr),  64'h1000);
    check("f_size",  64'(m_size),  64'(SIZE_WORD));
    check("f_instr", 64'(m_instr), 64'h1);
    mem_data = 32'hCAFE_F00D;
    mem_dv   = 1'b1;
    #2;
    check("f_pulse", 64'({i_dv, d_dv}), 64'b10);
    check("f_data",  64'(i_data),       64'hCAFE_F00D);
    next_cycle();
    i_rd_req = 1'b0;
    mem_dv   = 1'b0;
    #2;
    check("f_done", 64'(m_rdv), 64'h0);

    // store latches data/address/size
    d_addr = 32'h2004; d_wr_data = 32'hDEAD_BEEF; d_size = SIZE_WORD; d_wr_req = 1'b1;
    next_cycle();
    d_addr = 32'h0; d_wr_data = 32'h0; d_size = SIZE_BYTE;
    #2;
    check("s_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
    check("s_addr",  64'(m_addr),  64'h2004);
    check("s_size",  64'(m_size),  64'(SIZE_WORD));
    check("s_valid", 64'({m_wrv, m_instr}), 64'b10);
    next_cycle();
    mem_wd = 1'b1;
    #2;
    check("s_pulse", 64'({d_wd, d_dv}), 64'b10);
    next_cycle();
    d_wr_req = 1'b0;
    mem_wd   = 1'b0;
    #2;
    check("s_idle", 64'({m_wrv, d_wd}), 64'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
